// File: rtl/gift_pkg.sv
// Shared widths and types for the GIFT encryptor datapath and its output stages.
package gift_pkg;
   localparam int GIFT_BLOCK_W         = 128;
   localparam int GIFT_WORD_W          = 32;
   localparam int GIFT_WORDS_PER_BLOCK = 4;
   localparam int GIFT_IDX_W           = $clog2(GIFT_WORDS_PER_BLOCK);

   typedef logic [GIFT_BLOCK_W-1:0] giftBlock_t;
   typedef logic [GIFT_WORD_W-1:0]  giftWord_t;
endpackage

// File: rtl/gift_block_fifo.sv
// Block FIFO for ciphertext: accepts a block whenever there is room (or the head leaves
// in the same cycle), otherwise drops it and raises a sticky overflow flag.
module gift_block_fifo
   import gift_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             pushReq,
   input  giftBlock_t       pushData,
   input  logic             pop,
   output giftBlock_t       headData,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);
   localparam int PTR_W = $clog2(DEPTH);

   giftBlock_t       mem [DEPTH];
   logic [PTR_W-1:0] wrPtrReg;
   logic [PTR_W-1:0] rdPtrReg;
   logic [CNT_W-1:0] countReg;
   logic             overflowReg;
   logic             full;
   logic             pushEn;
   logic             dropEn;

   assign full   = (countReg == CNT_W'(DEPTH));
   // A full FIFO can still take a block if the head block finishes leaving this cycle.
   assign pushEn = pushReq & (~full | pop);
   assign dropEn = pushReq & full & ~pop;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         countReg    <= '0;
         overflowReg <= 1'b0;
      end else begin
         if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
         if (pop)    rdPtrReg <= rdPtrReg + PTR_W'(1);
         case ({pushEn, pop})
            2'b10:   countReg <= countReg + CNT_W'(1);
            2'b01:   countReg <= countReg - CNT_W'(1);
            default: countReg <= countReg;
         endcase
         if (dropEn) overflowReg <= 1'b1;
      end
   end

   // Storage carries no reset; stale contents are never visible while count is zero.
   always_ff @(posedge clk) begin
      if (pushEn) mem[wrPtrReg] <= pushData;
   end

   assign headData = mem[rdPtrReg];
   assign count    = countReg;
   assign overflow = overflowReg;
endmodule

// File: rtl/gift_pipe_out_serializer.sv
// Buffers 128-bit ciphertext blocks and streams them out as 32-bit words, MS word first,
// over a valid/ready handshake. All outputs come from registers only.
module gift_pipe_out_serializer
   import gift_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WORD_W = GIFT_WORD_W
) (
   input  logic                       inClk,
   input  logic                       inRstN,
   input  logic                       inValidData,
   input  logic [GIFT_BLOCK_W-1:0]    inData,
   input  logic                       inWordReady,
   output logic [WORD_W-1:0]          outWord,
   output logic                       outWordValid,
   output logic                       outWordLast,
   output logic [$clog2(DEPTH+1)-1:0] outLevel,
   output logic                       outFull,
   output logic                       outOverflow
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int WORDS = GIFT_BLOCK_W / WORD_W;

   giftBlock_t            headData;
   logic [CNT_W-1:0]      count;
   logic [GIFT_IDX_W-1:0] idxReg;
   logic [WORD_W-1:0]     wordSlice [WORDS];
   logic                  wordValid;
   logic                  transfer;
   logic                  finalPop;

   assign wordValid = (count != '0);
   assign transfer  = wordValid & inWordReady;
   assign finalPop  = transfer & (idxReg == GIFT_IDX_W'(WORDS - 1));

   gift_block_fifo #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) uFifo (
      .clk     (inClk),
      .rstN    (inRstN),
      .pushReq (inValidData),
      .pushData(inData),
      .pop     (finalPop),
      .headData(headData),
      .count   (count),
      .overflow(outOverflow)
   );

   // Word 0 is the most-significant slice of the block.
   for (genvar gi = 0; gi < WORDS; gi++) begin : gWordSlice
      assign wordSlice[gi] = headData[GIFT_BLOCK_W-1-gi*WORD_W -: WORD_W];
   end

   always_ff @(posedge inClk) begin
      if (!inRstN)       idxReg <= '0;
      else if (transfer) idxReg <= idxReg + GIFT_IDX_W'(1);
   end

   assign outWord      = wordSlice[idxReg];
   assign outWordValid = wordValid;
   assign outWordLast  = wordValid & (idxReg == GIFT_IDX_W'(WORDS - 1));
   assign outLevel     = count;
   assign outFull      = (count == CNT_W'(DEPTH));
endmodule

// File: tb/tb_gift_pipe_out_serializer.sv
// Directed and random stimulus for the block serializer against a queue-based block model.
module tb_gift_pipe_out_serializer;
   localparam int DEPTH = 4;

   logic         inClk = 1'b0;
   logic         inRstN = 1'b0;
   logic         inValidData = 1'b0;
   logic [127:0] inData = '0;
   logic         inWordReady = 1'b0;
   logic [31:0]  outWord;
   logic         outWordValid;
   logic         outWordLast;
   logic [2:0]   outLevel;
   logic         outFull;
   logic         outOverflow;

   gift_pipe_out_serializer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
      .inClk       (inClk),
      .inRstN      (inRstN),
      .inValidData (inValidData),
      .inData      (inData),
      .inWordReady (inWordReady),
      .outWord     (outWord),
      .outWordValid(outWordValid),
      .outWordLast (outWordLast),
      .outLevel    (outLevel),
      .outFull     (outFull),
      .outOverflow (outOverflow)
   );

   always #5 inClk = ~inClk;

   // Reference: queue of whole blocks, index of the next word of the head, sticky drop flag.
   logic [127:0] modelQ [$];
   int           mIdx = 0;
   bit           mOvf = 1'b0;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkModel();
      logic [127:0] head;
      int n;
      n = modelQ.size();
      chk("valid", 128'(outWordValid), 128'(n != 0));
      if (n != 0) begin
         head = modelQ[0];
         chk("word", 128'(outWord), 128'(head[127-32*mIdx -: 32]));
      end
      chk("last", 128'(outWordLast), 128'(n != 0 && mIdx == 3));
      chk("level", 128'(outLevel), 128'(n));
      chk("full", 128'(outFull), 128'(n == DEPTH));
      chk("overflow", 128'(outOverflow), 128'(mOvf));
   endtask

   // One clock: drive inputs, advance the model, then check settled outputs at negedge.
   task automatic cycle(input bit v, input logic [127:0] d, input bit r);
      bit xfer, fin, doPush;
      inValidData = v;
      inData      = d;
      inWordReady = r;
      xfer   = (modelQ.size() != 0) && r;
      fin    = xfer && (mIdx == 3);
      doPush = 1'b0;
      if (v) begin
         if (modelQ.size() < DEPTH || fin) doPush = 1'b1;
         else mOvf = 1'b1;
      end
      if (xfer) mIdx = (mIdx + 1) % 4;
      if (fin) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(d);
      @(posedge inClk);
      @(negedge inClk);
      checkModel();
   endtask

   task automatic doReset();
      inRstN      = 1'b0;
      inValidData = 1'b1;
      inData      = {$urandom, $urandom, $urandom, $urandom};
      inWordReady = 1'b1;
      @(posedge inClk);
      @(negedge inClk);
      modelQ.delete();
      mIdx   = 0;
      mOvf   = 1'b0;
      inRstN = 1'b1;
      inValidData = 1'b0;
      checkModel();
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] blk;
      logic [127:0] blk2;
      logic [31:0]  expW [4];
      blk  = 128'h0123456789ABCDEF_FEDCBA9876543210;
      expW = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};

      @(negedge inClk);
      doReset();
      chk("reset_level", 128'(outLevel), 128'(0));

      // Single block, consumer always ready.
      cycle(1'b1, blk, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("single_word", 128'(outWord), 128'(expW[k]));
         chk("single_last", 128'(outWordLast), 128'(k == 3));
         cycle(1'b0, '0, 1'b1);
      end
      chk("single_level_end", 128'(outLevel), 128'(0));

      // Backpressure: five stalled cycles then drain.
      cycle(1'b1, blk, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("stall_word", 128'(outWord), 128'(expW[0]));
         cycle(1'b0, '0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         chk("resume_word", 128'(outWord), 128'(expW[k]));
         cycle(1'b0, '0, 1'b1);
      end

      // Fill to DEPTH, then one dropped block, then drain.
      for (int b = 0; b < 5; b++) begin
         cycle(1'b1, rnd128(), 1'b0);
         if (b == 3) chk("fill_full", 128'(outFull), 128'(1));
      end
      chk("fill_overflow", 128'(outOverflow), 128'(1));
      for (int k = 0; k < 16; k++) cycle(1'b0, '0, 1'b1);
      chk("fill_drained", 128'(outLevel), 128'(0));

      // Full FIFO with block-final pop in the same cycle as a strobe.
      doReset();
      for (int b = 0; b < 4; b++) cycle(1'b1, rnd128(), 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, rnd128(), 1'b1);
      chk("fullpop_level", 128'(outLevel), 128'(4));
      chk("fullpop_overflow", 128'(outOverflow), 128'(0));
      for (int k = 0; k < 16; k++) cycle(1'b0, '0, 1'b1);

      // Pointer wrap at sustained rate.
      doReset();
      for (int b = 0; b < 10; b++) begin
         cycle(1'b1, rnd128(), 1'b1);
         for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1);
      chk("wrap_overflow", 128'(outOverflow), 128'(0));

      // Reset after two words of a block discards it; next block starts at word 0.
      cycle(1'b1, rnd128(), 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      doReset();
      chk("midreset_valid", 128'(outWordValid), 128'(0));
      blk2 = rnd128();
      cycle(1'b1, blk2, 1'b0);
      chk("midreset_word0", 128'(outWord), 128'(blk2[127:96]));

      // Random traffic.
      for (int k = 0; k < 2000; k++)
         cycle($urandom_range(0, 2) == 0, rnd128(), $urandom_range(0, 3) != 0);
      for (int k = 0; k < 3000; k++)
         cycle($urandom_range(0, 1) == 0, rnd128(), $urandom_range(0, 3) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
